// File: rtl/blinkled_memtest_master.sv
// rtl/blinkled_memtest_master.sv - Avalon-MM write/readback memory test master
// Optional: BLINKLED_MEMTEST_INVERT_PASS_EN adds a second pass using the inverted pattern.
module blinkled_memtest_master #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic [DATA_W-1:0]   seed,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = ADDR_W + 1;
    localparam int RL    = READ_LATENCY;

`ifdef BLINKLED_MEMTEST_INVERT_PASS_EN
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_PASS2, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]   ferr_q, ferr_d;

`ifdef BLINKLED_MEMTEST_INVERT_PASS_EN
    logic                inv_q, inv_d;
`else
    logic                inv_q;
    assign inv_q = 1'b0;
`endif

    // Stage 0 mirrors the read currently on the bus; stage RL lines up with avm_readdata.
    logic [RL:0]         pv_q, pv_d;
    logic [DATA_W-1:0]   pexp_q [0:RL];
    logic [DATA_W-1:0]   pexp_d [0:RL];
    logic [ADDR_W-1:0]   paddr_q [0:RL];
    logic [ADDR_W-1:0]   paddr_d [0:RL];

    logic                last;
    logic [CNT_W-1:0]    nxt_idx;
    logic [ADDR_W-1:0]   nxt_addr;
    logic [DATA_W-1:0]   nxt_pat;
    logic [DATA_W-1:0]   first_pat;
    logic                issue_rd;
    logic [DATA_W-1:0]   rd_exp;
    logic [ADDR_W-1:0]   rd_addr;
    logic                mismatch;

    always_comb begin
        last      = (idx_q == cnt_q - 1'b1);
        nxt_idx   = idx_q + 1'b1;
        nxt_addr  = base_q + nxt_idx[ADDR_W-1:0];
        nxt_pat   = (seed_q + DATA_W'(nxt_idx)) ^ {DATA_W{inv_q}};
        first_pat = seed_q ^ {DATA_W{inv_q}};
        mismatch  = pv_q[RL] && (avm_readdata != pexp_q[RL]);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        seed_d   = seed_q;
`ifdef BLINKLED_MEMTEST_INVERT_PASS_EN
        inv_d    = inv_q;
`endif
        addr_d   = addr_q;
        cs_d     = 1'b0;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        pass_d   = pass_q;
        err_d    = err_q;
        ferr_d   = ferr_q;
        issue_rd = 1'b0;
        rd_exp   = '0;
        rd_addr  = '0;

        if (mismatch) begin
            if (err_q != '1) begin
                err_d = err_q + 1'b1;
            end
            if (err_q == '0) begin
                ferr_d = paddr_q[RL];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d  = word_count;
                    base_d = base_addr;
                    seed_d = seed;
                    idx_d  = '0;
                    err_d  = '0;
                    ferr_d = '0;
                    pass_d = 1'b0;
`ifdef BLINKLED_MEMTEST_INVERT_PASS_EN
                    inv_d  = 1'b0;
`endif
                    // An empty range still passes through DRAIN so done keeps a fixed two-cycle latency.
                    if (word_count == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_WRITE;
                        cs_d    = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = base_addr;
                        wdata_d = seed;
                    end
                end
            end
            S_WRITE: begin
                cs_d = 1'b1;
                if (last) begin
                    state_d  = S_READ;
                    idx_d    = '0;
                    addr_d   = base_q;
                    issue_rd = 1'b1;
                    rd_exp   = first_pat;
                    rd_addr  = base_q;
                end else begin
                    idx_d   = nxt_idx;
                    we_d    = 1'b1;
                    addr_d  = nxt_addr;
                    wdata_d = nxt_pat;
                end
            end
            S_READ: begin
                if (last) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d    = nxt_idx;
                    cs_d     = 1'b1;
                    addr_d   = nxt_addr;
                    issue_rd = 1'b1;
                    rd_exp   = nxt_pat;
                    rd_addr  = nxt_addr;
                end
            end
            S_DRAIN: begin
                if (pv_q[RL-1:0] == '0) begin
`ifdef BLINKLED_MEMTEST_INVERT_PASS_EN
                    state_d = inv_q ? S_DONE : S_PASS2;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef BLINKLED_MEMTEST_INVERT_PASS_EN
            S_PASS2: begin
                inv_d = 1'b1;
                idx_d = '0;
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WRITE;
                    cs_d    = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = base_q;
                    wdata_d = ~seed_q;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pv_d       = {pv_q[RL-1:0], issue_rd};
        pexp_d[0]  = rd_exp;
        paddr_d[0] = rd_addr;
        for (int k = 1; k <= RL; k++) begin
            pexp_d[k]  = pexp_q[k-1];
            paddr_d[k] = paddr_q[k-1];
        end

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        if (state_d == S_DONE) begin
            pass_d = (err_d == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            seed_q  <= '0;
`ifdef BLINKLED_MEMTEST_INVERT_PASS_EN
            inv_q   <= 1'b0;
`endif
            addr_q  <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
            pv_q    <= '0;
            for (int k = 0; k <= RL; k++) begin
                pexp_q[k]  <= '0;
                paddr_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            seed_q  <= seed_d;
`ifdef BLINKLED_MEMTEST_INVERT_PASS_EN
            inv_q   <= inv_d;
`endif
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            pv_q    <= pv_d;
            for (int k = 0; k <= RL; k++) begin
                pexp_q[k]  <= pexp_d[k];
                paddr_q[k] <= paddr_d[k];
            end
        end
    end

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write      = we_q;
    assign avm_byteenable = {BE_W{cs_q}};
    assign avm_writedata  = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_blinkled_memtest_master.sv
// tb/tb_blinkled_memtest_master.sv - scoreboard bench for blinkled_memtest_master
// Honours BLINKLED_MEMTEST_INVERT_PASS_EN when computing expectations.
module tb_blinkled_memtest_master;
`ifdef BLINKLED_MEMTEST_INVERT_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam int NVEC = 9;

    typedef struct {
        int          inst;
        logic [15:0] base;
        logic [16:0] cnt;
        logic [31:0] seed;
        int          fault;
        int          action;
    } vec_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        int          lat;
        logic        pass;
        logic [16:0] errs;
        logic [15:0] first;
        int          nxfer;
        int          xbase;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // fault: 0 none, 1 bit 0 of 0x0012 stuck at 0 on read, 2 every read inverted
    // action: 0 plain run, 1 second start during WRITE, 2 reset during READ
    function automatic vec_t get_vec(int k);
        vec_t v;
        case (k)
            0:       v = '{0, 16'h0010, 17'd4, 32'hA5A5_0000, 0, 0};
            1:       v = '{0, 16'h0010, 17'd4, 32'h0000_0001, 1, 0};
            2:       v = '{0, 16'hFFFE, 17'd4, 32'hDEAD_0000, 0, 0};
            3:       v = '{0, 16'h0040, 17'd0, 32'h0000_0007, 0, 0};
            4:       v = '{0, 16'h0020, 17'd6, 32'h0000_0100, 0, 1};
            5:       v = '{0, 16'h0030, 17'd5, 32'h0000_0055, 0, 2};
            6:       v = '{0, 16'h0030, 17'd5, 32'h0000_0077, 0, 0};
            7:       v = '{1, 16'h0100, 17'd8, 32'h1234_5678, 2, 0};
            default: v = '{1, 16'h0200, 17'd3, 32'hCAFE_0000, 0, 0};
        endcase
        return v;
    endfunction

    function automatic logic [31:0] pat(logic [31:0] s, int i, int p);
        logic [31:0] d;
        d = s + 32'(i);
        return (p != 0) ? ~d : d;
    endfunction

    function automatic logic mism(int f, logic [15:0] a, logic [31:0] d);
        if (f == 2) return 1'b1;
        if (f == 1) return (a == 16'h0012) && d[0];
        return 1'b0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int RL = (g == 0) ? 1 : 3;

        logic        reset_n;
        logic        start;
        logic [15:0] base_addr;
        logic [16:0] word_count;
        logic [31:0] seed;
        logic [15:0] avm_address;
        logic        avm_chipselect;
        logic        avm_write;
        logic [3:0]  avm_byteenable;
        logic [31:0] avm_writedata;
        logic [31:0] avm_readdata;
        logic        busy;
        logic        done;
        logic        pass;
        logic [16:0] err_count;
        logic [15:0] first_err_addr;

        int          fault = 0;
        int          cyc = 0;
        int          start_cyc = 0;
        int          nxfer = 0;
        logic        fin_i = 1'b0;
        xfer_t       xq[$];
        res_t        rq[$];
        xfer_t       me;
        res_t        mr;
        int          mlat;
        logic [31:0] mem [0:65535];
        logic [31:0] rpipe [0:2];

        blinkled_memtest_master #(
            .ADDR_W(16),
            .DATA_W(32),
            .READ_LATENCY(RL)
        ) dut (
            .clk(clk),
            .reset_n(reset_n),
            .start(start),
            .base_addr(base_addr),
            .word_count(word_count),
            .seed(seed),
            .avm_address(avm_address),
            .avm_chipselect(avm_chipselect),
            .avm_write(avm_write),
            .avm_byteenable(avm_byteenable),
            .avm_writedata(avm_writedata),
            .avm_readdata(avm_readdata),
            .busy(busy),
            .done(done),
            .pass(pass),
            .err_count(err_count),
            .first_err_addr(first_err_addr)
        );

        // RAM model: read data appears RL cycles after the cycle the read is on the bus.
        always @(posedge clk) begin
            cyc <= cyc + 1;
            if (avm_chipselect && avm_write) mem[avm_address] <= avm_writedata;
            if (fault == 2)
                rpipe[0] <= ~mem[avm_address];
            else if (fault == 1 && avm_address == 16'h0012)
                rpipe[0] <= mem[avm_address] & ~32'h1;
            else
                rpipe[0] <= mem[avm_address];
            rpipe[1] <= rpipe[0];
            rpipe[2] <= rpipe[1];
        end
        assign avm_readdata = rpipe[RL-1];

        always @(negedge clk) begin
            if (reset_n) begin
                if (avm_chipselect) begin
                    nxfer++;
                    checks++;
                    if (xq.size() == 0) begin
                        failures++;
                        $display("FAIL dut%0d unexpected_xfer got we=%0b addr=%h want none", g, avm_write, avm_address);
                    end else begin
                        me = xq.pop_front();
                        if (avm_write !== me.we || avm_address !== me.addr || avm_byteenable !== 4'hF ||
                            (me.we && avm_writedata !== me.data)) begin
                            failures++;
                            $display("FAIL dut%0d xfer got we=%0b addr=%h be=%h data=%h want we=%0b addr=%h be=f data=%h",
                                     g, avm_write, avm_address, avm_byteenable, avm_writedata, me.we, me.addr, me.data);
                        end
                    end
                end
                if (done) begin
                    checks++;
                    if (rq.size() == 0) begin
                        failures++;
                        $display("FAIL dut%0d unexpected_done got done=1 want 0", g);
                    end else begin
                        mr = rq.pop_front();
                        mlat = cyc - start_cyc;
                        if (mlat != mr.lat || pass !== mr.pass || err_count !== mr.errs ||
                            first_err_addr !== mr.first || (nxfer - mr.xbase) != mr.nxfer || busy !== 1'b0) begin
                            failures++;
                            $display("FAIL dut%0d result got lat=%0d pass=%0b err=%0d first=%h xfers=%0d busy=%0b want lat=%0d pass=%0b err=%0d first=%h xfers=%0d busy=0",
                                     g, mlat, pass, err_count, first_err_addr, nxfer - mr.xbase, busy,
                                     mr.lat, mr.pass, mr.errs, mr.first, mr.nxfer);
                        end
                    end
                end
            end
        end

        vec_t        v;
        int          n;
        logic [16:0] errs;
        logic [15:0] first;
        logic [15:0] a;
        logic [31:0] d;

        initial begin
            reset_n = 1'b0;
            start = 1'b0;
            base_addr = '0;
            word_count = '0;
            seed = '0;
            repeat (3) @(negedge clk);
            checks++;
            if ({busy, done, pass, err_count, first_err_addr, avm_chipselect, avm_write,
                 avm_address, avm_byteenable, avm_writedata} !== '0) begin
                failures++;
                $display("FAIL dut%0d reset_state got busy=%0b done=%0b pass=%0b err=%0d cs=%0b want all 0",
                         g, busy, done, pass, err_count, avm_chipselect);
            end
            reset_n = 1'b1;
            @(negedge clk);

            for (int k = 0; k < NVEC; k++) begin
                v = get_vec(k);
                if (v.inst == g) begin
                    fault = v.fault;
                    n = int'(v.cnt);
                    errs = '0;
                    first = '0;
                    for (int p = 0; p < NPASS; p++) begin
                        for (int i = 0; i < n; i++) begin
                            a = v.base + 16'(i);
                            xq.push_back('{we: 1'b1, addr: a, data: pat(v.seed, i, p)});
                        end
                        for (int i = 0; i < n; i++) begin
                            a = v.base + 16'(i);
                            d = pat(v.seed, i, p);
                            xq.push_back('{we: 1'b0, addr: a, data: 32'h0});
                            if (mism(v.fault, a, d)) begin
                                if (errs == '0) first = a;
                                errs = errs + 1'b1;
                            end
                        end
                    end
                    rq.push_back('{lat: (n == 0) ? 2 * NPASS : NPASS * (2 * n + RL + 1),
                                   pass: (errs == '0), errs: errs, first: first,
                                   nxfer: 2 * n * NPASS, xbase: nxfer});

                    start = 1'b1;
                    base_addr = v.base;
                    word_count = v.cnt;
                    seed = v.seed;
                    start_cyc = cyc;
                    @(negedge clk);
                    start = 1'b0;
                    base_addr = ~v.base;
                    word_count = 17'd3;
                    seed = ~v.seed;

                    if (v.action == 1) begin
                        repeat (2) @(negedge clk);
                        start = 1'b1;
                        base_addr = 16'h3000;
                        word_count = 17'd5;
                        @(negedge clk);
                        start = 1'b0;
                    end

                    if (v.action == 2) begin
                        repeat (n + 1) @(negedge clk);
                        reset_n = 1'b0;
                        xq.delete();
                        rq.delete();
                        @(negedge clk);
                        checks++;
                        if ({busy, done, pass, err_count, first_err_addr, avm_chipselect,
                             avm_write, avm_address, avm_byteenable} !== '0) begin
                            failures++;
                            $display("FAIL dut%0d mid_reset got busy=%0b cs=%0b addr=%h err=%0d want all 0",
                                     g, busy, avm_chipselect, avm_address, err_count);
                        end
                        reset_n = 1'b1;
                        @(negedge clk);
                    end else begin
                        for (int t = 0; t < 500 && rq.size() > 0; t++) @(negedge clk);
                        if (rq.size() > 0) begin
                            checks++;
                            failures++;
                            $display("FAIL dut%0d done_timeout got no done want done within 500 cycles", g);
                            rq.delete();
                        end
                        checks++;
                        if (xq.size() != 0) begin
                            failures++;
                            $display("FAIL dut%0d missing_xfers got %0d outstanding want 0", g, xq.size());
                            xq.delete();
                        end
                        @(negedge clk);
                    end
                end
            end
            fin_i = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && !(g_dut[0].fin_i && g_dut[1].fin_i); t++) @(negedge clk);
        if (!(g_dut[0].fin_i && g_dut[1].fin_i)) begin
            checks++;
            failures++;
            $display("FAIL global_timeout got unfinished want both sequences finished");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
